// File: rtl/vga_ctrl_pkg.sv
// Shared VGA-control types: divider speed codes and the key FSM state encoding.
// Pure declarations; no latency, no flow control.
package vga_ctrl_pkg;

  localparam logic [1:0] FAST_NORMAL = 2'd0;
  localparam logic [1:0] FAST_MID    = 2'd1;
  localparam logic [1:0] FAST_MAX    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } key_state_e;

  // Cycles normal -> mid -> max -> normal; the unused code 3 falls back to normal.
  function automatic logic [1:0] fast_advance(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      FAST_NORMAL: nxt = FAST_MID;
      FAST_MID:    nxt = FAST_MAX;
      default:     nxt = FAST_NORMAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clkin cycles, at the terminal count.
// Tick is decoded from the counter register; no input dependency, never stalls.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic clkin,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/key_speed_ctrl.sv
// Debounced push-button that steps the divider speed code on short presses, resets it on long ones.
// Outputs registered one clkin after the deciding tick; input seen 2 cycles + up to one tick late.
module key_speed_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       key_n,
  output logic [1:0] fast,
  output logic       step_pulse,
  output logic       key_level
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HW  = $clog2(LONG_MS + 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_MS);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_MS);
  localparam logic [HW-1:0]  HOLD_PRE  = HW'(LONG_MS - 1);

  logic tick;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clkin(clkin),
    .rst  (rst),
    .tick (tick)
  );

  // Flops reset to the released level so reset exit never looks like a press.
  logic sync1_q;
  logic sync2_q;
  logic pressed_s;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  key_state_e     state_q, state_d;
  logic [DBW-1:0] db_q, db_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           long_q, long_d;
  logic [1:0]     fast_q, fast_d;
  logic           pulse_q, pulse_d;
  logic           level_q, level_d;

  logic [DBW-1:0] db_inc;
  logic           hold_reach;

  assign db_inc     = db_q + 1'b1;
  assign hold_reach = (hold_q == HOLD_PRE);

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    hold_d  = hold_q;
    long_d  = long_q;
    fast_d  = fast_q;
    pulse_d = 1'b0;
    level_d = level_q;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (pressed_s) begin
            state_d = ST_PRESS_DB;
            db_d    = DB_ONE;
          end
        end

        ST_PRESS_DB: begin
          if (!pressed_s) begin
            state_d = ST_IDLE;
          end else begin
            db_d = db_inc;
            if (db_inc == DB_LAST) begin
              state_d = ST_HELD;
              level_d = 1'b1;
              hold_d  = '0;
              long_d  = 1'b0;
            end
          end
        end

        ST_HELD: begin
          // A release sample on the reaching tick still counts: the long press wins.
          if ((pressed_s || hold_reach) && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + 1'b1;
          end
          if (hold_reach) begin
            long_d  = 1'b1;
            fast_d  = FAST_NORMAL;
            pulse_d = 1'b1;
          end
          if (!pressed_s) begin
            state_d = ST_RELEASE_DB;
            db_d    = DB_ONE;
          end
        end

        ST_RELEASE_DB: begin
          if (pressed_s) begin
            state_d = ST_HELD;
          end else begin
            db_d = db_inc;
            if (db_inc == DB_LAST) begin
              state_d = ST_IDLE;
              level_d = 1'b0;
              if (!long_q) begin
                fast_d  = fast_advance(fast_q);
                pulse_d = 1'b1;
              end
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      db_q    <= '0;
      hold_q  <= '0;
      long_q  <= 1'b0;
      fast_q  <= FAST_NORMAL;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      long_q  <= long_d;
      fast_q  <= fast_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign fast       = fast_q;
  assign step_pulse = pulse_q;
  assign key_level  = level_q;

endmodule

// File: tb/tb_key_speed_ctrl.sv
// Directed bench for key_speed_ctrl with TICK_DIV=4, DEBOUNCE_MS=3, LONG_MS=10.
// Each step() presents one key sample and returns just after the tick edge that consumed it.
module tb_key_speed_ctrl;

  logic       clkin;
  logic       rst;
  logic       key_n;
  logic [1:0] fast;
  logic       step_pulse;
  logic       key_level;

  int n_checks;
  int n_fail;
  int pulse_cnt;
  int p0;
  logic [1:0] exp_fast;

  key_speed_ctrl #(
    .TICK_DIV   (4),
    .DEBOUNCE_MS(3),
    .LONG_MS    (10)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .key_n     (key_n),
    .fast      (fast),
    .step_pulse(step_pulse),
    .key_level (key_level)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  always @(posedge clkin) begin
    if (step_pulse === 1'b1) pulse_cnt++;
  end

  always @(negedge clkin) begin
    if (rst === 1'b0) begin
      n_checks++;
      if ($isunknown(fast) || fast == 2'd3) begin
        n_fail++;
        $display("FAIL fast_legal: got %b expected 0..2", fast);
      end
    end
  end

  task automatic step(input logic k_n);
    key_n = k_n;
    repeat (4) @(posedge clkin);
    #1;
  endtask

  task automatic press_release(input int hold_ticks, input int rel_ticks);
    repeat (hold_ticks) step(1'b0);
    repeat (rel_ticks) step(1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_n = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected 0000", {fast, step_pulse, key_level});
    end
    rst = 1'b0;
    pulse_cnt = 0;
    repeat (4) step(1'b1);
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0000 || pulse_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_exit: got %b pulses=%0d expected 0000 pulses=0",
               {fast, step_pulse, key_level}, pulse_cnt);
    end
    exp_fast = 2'd0;
  endtask

  task automatic test_short_presses;
    logic [1:0] prev;
    for (int i = 0; i < 3; i++) begin
      prev = exp_fast;
      p0 = pulse_cnt;
      repeat (3) step(1'b0);
      n_checks++;
      if ({fast, step_pulse, key_level} !== {prev, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL short_accept%0d: got %b expected %b", i, {fast, step_pulse, key_level}, {prev, 2'b01});
      end
      repeat (3) step(1'b0);
      step(1'b1);
      step(1'b1);
      n_checks++;
      if ({fast, step_pulse, key_level} !== {prev, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL short_rel_db%0d: got %b expected %b", i, {fast, step_pulse, key_level}, {prev, 2'b01});
      end
      step(1'b1);
      exp_fast = (prev == 2'd2) ? 2'd0 : prev + 2'd1;
      n_checks++;
      if ({fast, step_pulse, key_level} !== {exp_fast, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL short_step%0d: got %b expected %b", i, {fast, step_pulse, key_level}, {exp_fast, 2'b10});
      end
      step(1'b1);
      n_checks++;
      if ({fast, step_pulse, key_level} !== {exp_fast, 1'b0, 1'b0} || pulse_cnt - p0 != 1) begin
        n_fail++;
        $display("FAIL short_single%0d: got %b pulses=%0d expected %b pulses=1",
                 i, {fast, step_pulse, key_level}, pulse_cnt - p0, {exp_fast, 2'b00});
      end
    end
  endtask

  task automatic test_bounce;
    p0 = pulse_cnt;
    for (int g = 0; g < 2; g++) begin
      step(1'b0);
      step(1'b0);
      step(1'b1);
      n_checks++;
      if ({fast, step_pulse, key_level} !== {exp_fast, 2'b00}) begin
        n_fail++;
        $display("FAIL bounce_press%0d: got %b expected %b", g, {fast, step_pulse, key_level}, {exp_fast, 2'b00});
      end
    end
    repeat (5) step(1'b0);
    for (int g = 0; g < 2; g++) begin
      step(1'b1);
      n_checks++;
      if ({fast, step_pulse, key_level} !== {exp_fast, 2'b01}) begin
        n_fail++;
        $display("FAIL bounce_release%0d: got %b expected %b", g, {fast, step_pulse, key_level}, {exp_fast, 2'b01});
      end
      step(1'b0);
      step(1'b0);
    end
    n_checks++;
    if (pulse_cnt != p0 || key_level !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_nopulse: got pulses=%0d level=%b expected 0 and 1", pulse_cnt - p0, key_level);
    end
    repeat (3) step(1'b1);
    exp_fast = 2'd1;
    n_checks++;
    if ({fast, step_pulse, key_level} !== {exp_fast, 2'b10}) begin
      n_fail++;
      $display("FAIL bounce_final: got %b expected %b", {fast, step_pulse, key_level}, {exp_fast, 2'b10});
    end
  endtask

  task automatic test_long_press;
    press_release(6, 4);
    exp_fast = 2'd2;
    n_checks++;
    if (fast !== exp_fast) begin
      n_fail++;
      $display("FAIL long_setup: got %0d expected %0d", fast, exp_fast);
    end
    p0 = pulse_cnt;
    repeat (12) step(1'b0);
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b1001) begin
      n_fail++;
      $display("FAIL long_before: got %b expected 1001", {fast, step_pulse, key_level});
    end
    step(1'b0);
    exp_fast = 2'd0;
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0011) begin
      n_fail++;
      $display("FAIL long_fire: got %b expected 0011", {fast, step_pulse, key_level});
    end
    repeat (2) step(1'b0);
    repeat (3) step(1'b1);
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL long_release: got %b expected 0000", {fast, step_pulse, key_level});
    end
    step(1'b1);
    n_checks++;
    if (pulse_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL long_pulses: got %0d expected 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_collision;
    press_release(6, 4);
    exp_fast = 2'd1;
    p0 = pulse_cnt;
    repeat (12) step(1'b0);
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0101) begin
      n_fail++;
      $display("FAIL coll_before: got %b expected 0101", {fast, step_pulse, key_level});
    end
    step(1'b1);
    exp_fast = 2'd0;
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0011) begin
      n_fail++;
      $display("FAIL coll_fire: got %b expected 0011", {fast, step_pulse, key_level});
    end
    repeat (4) step(1'b1);
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0000 || pulse_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL coll_after: got %b pulses=%0d expected 0000 pulses=1",
               {fast, step_pulse, key_level}, pulse_cnt - p0);
    end
  endtask

  task automatic test_reset_mid;
    press_release(6, 4);
    exp_fast = 2'd1;
    repeat (5) step(1'b0);
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0101) begin
      n_fail++;
      $display("FAIL rstmid_held: got %b expected 0101", {fast, step_pulse, key_level});
    end
    rst = 1'b1;
    #2;
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 0000", {fast, step_pulse, key_level});
    end
    key_n = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    rst = 1'b0;
    exp_fast = 2'd0;
    step(1'b1);
    p0 = pulse_cnt;
    press_release(6, 4);
    exp_fast = 2'd1;
    n_checks++;
    if ({fast, step_pulse, key_level} !== 4'b0100 || pulse_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got %b pulses=%0d expected 0100 pulses=1",
               {fast, step_pulse, key_level}, pulse_cnt - p0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    pulse_cnt = 0;
    exp_fast = 2'd0;
    rst = 1'b1;
    key_n = 1'b1;
    test_reset();
    test_short_presses();
    test_bounce();
    test_long_press();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_speed_ctrl.md
# key_speed_ctrl

Push-button front end that drives the 2-bit `fast` speed-select input of the clock divider in the VGA design. It synchronises and debounces one active-low board key, and advances the speed code on each short press: normal → mid → max → normal. A long press forces the code back to normal. It runs on the 50 MHz board clock alongside the divider and registers its output, so the divider sees a glitch-free select.

## Interface
Parameters:
- `TICK_DIV`, default 50_000: clkin cycles per 1 ms sample tick.
- `DEBOUNCE_MS`, default 20: consecutive stable ticks required to accept a press or a release.
- `LONG_MS`, default 1000: held ticks, counted after the press is accepted, that make a long press.

Ports:
- `clkin`, input, 1: 50 MHz clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `key_n`, input, 1: raw push button, active-low, asynchronous to clkin.
- `fast`, output, 2: speed code to the clock divider; 0 normal, 1 mid, 2 max; never 3.
- `step_pulse`, output, 1: one-cycle strobe in the cycle `fast` takes a new value.
- `key_level`, output, 1: debounced key state, 1 = pressed.

## Operation
- **Synchroniser:** `key_n` passes through a 2-flop synchroniser, then is inverted to `pressed_s`.
- **Tick generator:** the counter is free-running from reset and counts 0..TICK_DIV-1. It emits `tick` for one cycle at the terminal count. Key activity never restarts it.
- **FSM states:** IDLE, PRESS_DB, HELD, RELEASE_DB. Every transition is evaluated only on `tick` cycles.
- **IDLE:** if `pressed_s` = 1, go to PRESS_DB with `db_cnt` = 1.
- **PRESS_DB:**
  - `pressed_s` = 0 → IDLE.
  - Otherwise `db_cnt` += 1.
  - When `db_cnt` reaches DEBOUNCE_MS → HELD. Set `key_level` = 1, `hold_cnt` = 0, `long_flag` = 0.
- **HELD:**
  - `pressed_s` = 1: `hold_cnt` += 1, saturating at LONG_MS.
  - When `hold_cnt` first reaches LONG_MS: set `long_flag`, force `fast` = 0, pulse `step_pulse`. The pulse fires even if `fast` was already 0.
  - `pressed_s` = 0 → RELEASE_DB with `db_cnt` = 1.
- **RELEASE_DB:**
  - `pressed_s` = 1 → HELD. `hold_cnt` and `long_flag` are retained.
  - Otherwise `db_cnt` += 1.
  - When `db_cnt` reaches DEBOUNCE_MS → IDLE and `key_level` = 0. If `long_flag` = 0, advance `fast` (0→1, 1→2, 2→0, 3→0 defensively) and pulse `step_pulse`.
- **Widths:** counter widths are $clog2(max+1) of their respective parameter. No counter wraps: `db_cnt` is bounded by its state exits and `hold_cnt` saturates.

## Timing
- **Reset values:** `fast` = 0, `step_pulse` = 0, `key_level` = 0, FSM = IDLE, all counters 0, synchroniser flops = released.
- **Reset effect:** asserting `rst` mid-operation clears everything immediately (async). No step is issued on reset exit.
- **Input latency:** 2 cycles of synchroniser latency, plus up to TICK_DIV cycles until the next tick.
- **Press accepted:** DEBOUNCE_MS ticks after the first pressed sample.
- **Short-press step:** `fast` changes DEBOUNCE_MS ticks after the first released sample.
- **Register timing:** `fast`, `step_pulse` and `key_level` are registered and update in the clock edge after the deciding `tick` cycle.
- **Strobe width:** `step_pulse` is high exactly 1 clkin cycle per change; at most one per tick.
- **Simultaneous events:** a release sample on the same tick that `hold_cnt` reaches LONG_MS → the long-press action wins, and the state moves to RELEASE_DB with `long_flag` set.

## Structure
- **Shared package `vga_ctrl_pkg`:**
  - Speed codes FAST_NORMAL = 2'd0, FAST_MID = 2'd1, FAST_MAX = 2'd2.
  - The 2-bit FSM state encoding.
- **Sub-module `ms_tick_gen`:** the parameterised tick generator (ports `clkin`, `rst`, `tick`). It is reused by other key or timer blocks in the design.

## Test plan
Bench parameters: TICK_DIV = 4, DEBOUNCE_MS = 3, LONG_MS = 10.
- **Reset:** apply `rst` with `key_n` = 1 → `fast` = 0, `step_pulse` = 0, `key_level` = 0; no pulse after `rst` deasserts.
- **Short presses:** hold the key for 6 ticks, release, and repeat three times → `fast` goes 1, 2, 0. There is exactly one `step_pulse` per press, 3 ticks after each release, and `key_level` is high during each hold.
- **Bounce rejection:** 2-tick press glitches, and 1-tick releases during HELD → `fast` unchanged, no `step_pulse`, `key_level` stays high through the release glitches.
- **Long press:** with `fast` = 2, hold for 15 ticks, then release → `fast` = 0 with one pulse at the 10th held tick. No change and no pulse on release.
- **Collision:** a release coincides with the 10th held tick → `fast` = 0, one pulse only, and no advance after the release debounce.
- **Reset mid-operation:** assert `rst` while in HELD with `fast` = 1 → all outputs are 0 immediately. After release, a fresh short press gives `fast` = 1.
